instr_fetch_unit: RTL and testbench

//   Upstream stage of the processor: owns the program counter and reads 16-bit instruction words from memory.

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module  : instr_fetch_unit_pkg
// Brief   : Shared definitions for the instruction fetch unit (state
//           encoding and instruction word width).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Brief   : Small prefetch FIFO. Head word is driven straight from storage;
//           clear empties the buffer and overrides push/pop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_do_push;
  logic             w_do_pop;

  // Popping an empty buffer is a no-op; a push into a full buffer is only
  // accepted when a pop frees the slot in the same cycle.
  assign w_do_pop  = pop_i && (count_q != '0);
  assign w_do_push = push_i && ((count_q != FULL_CNT) || w_do_pop);

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy; storage is cleared on reset so the head
  // never shows X before the first word arrives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : Owns the program counter, issues single outstanding reads to
//           instruction memory and buffers returned words for the core.
//           Supports PC redirect with buffer flush and in-flight drop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic               Run,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_valid,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] iin,
  output logic               iin_valid,
  input  logic               Done,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic [ADDR_W-1:0]  pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              drop_q, drop_d;

  logic              w_push;
  logic              w_pop;
  logic              w_clear;
  logic [CNT_W-1:0]  w_count;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (Reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .clear_i (w_clear),
    .data_i  (mem_data),
    .head_o  (iin),
    .count_o (w_count)
  );

  assign iin_valid = (w_count != '0);
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign pc        = pc_q;

  // State, PC, drop flag and memory request registers.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state logic: redirect wins over everything; otherwise issue one
  // request at a time, only when the returning word is sure to have a slot
  // (with nothing in flight in REQ, a free slot means count < depth).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    drop_d     = drop_q;
    w_push     = 1'b0;
    w_pop      = Done;
    w_clear    = 1'b0;

    if (pc_load) begin
      pc_d    = pc_value;
      w_clear = 1'b1;
      w_pop   = 1'b0;
      if (state_q == ST_WAIT) begin
        if (mem_valid) begin
          // The in-flight word returns in this very cycle: discard it here
          // and stop waiting, otherwise nothing would ever end the wait.
          drop_d  = 1'b0;
          state_d = Run ? ST_REQ : ST_IDLE;
        end else begin
          drop_d = 1'b1;
        end
      end else begin
        state_d = Run ? ST_REQ : ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Run) begin
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if (!Run) begin
            state_d = ST_IDLE;
          end else if (w_count < DEPTH_CNT) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_valid) begin
            w_push  = !drop_q;
            drop_d  = 1'b0;
            state_d = Run ? ST_REQ : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module  : tb_instr_fetch_unit
// Brief   : Randomised bench for instr_fetch_unit with a queue-based
//           reference model and a variable-latency memory responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        Reset;
  logic        Run;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic [15:0] iin;
  logic        iin_valid;
  logic        Done;
  logic        pc_load;
  logic [7:0]  pc_value;
  logic [7:0]  pc;

  always #5 clock = ~clock;

  instr_fetch_unit #(
    .ADDR_W     (8),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .Reset     (Reset),
    .Run       (Run),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .iin       (iin),
    .iin_valid (iin_valid),
    .Done      (Done),
    .pc_load   (pc_load),
    .pc_value  (pc_value),
    .pc        (pc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: words the core should see, next fetch address,
  // in-flight request and whether its data must be discarded.
  logic [15:0] q[$];
  logic [7:0]  f;
  bit          outst;
  bit          dropf;
  logic [7:0]  req_addr;
  int          live;

  // Memory responder state.
  bit          m_pend;
  int          m_cnt;
  logic [7:0]  m_addr;

  // Stimulus knobs (percentages and latency range).
  int          p_run  = 100;
  int          p_done = 0;
  int          p_load = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          ld_now = 1'b0;
  logic [7:0]  ld_val = 8'h00;
  bit          stale_now = 1'b0;

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic cycle();
    bit just_req;
    just_req = 1'b0;
    @(negedge clock);

    check("iin_valid", iin_valid, (q.size() != 0));
    if (q.size() != 0) check("iin", iin, q[0]);
    if (mem_rd) begin
      check("rd_while_busy", outst, 0);
      check("rd_without_slot", (q.size() < DEPTH), 1);
      check("mem_addr", mem_addr, f);
      req_addr = f;
      f        = f + 8'd1;
      outst    = 1'b1;
      dropf    = 1'b0;
      m_pend   = 1'b1;
      m_addr   = mem_addr;
      m_cnt    = $urandom_range(lat_hi, lat_lo);
      just_req = 1'b1;
    end else if (outst) begin
      check("addr_hold", mem_addr, req_addr);
    end
    check("pc", pc, f);

    Run  = ($urandom_range(99) < p_run);
    Done = ($urandom_range(99) < p_done);
    if (ld_now) begin
      pc_load  = 1'b1;
      pc_value = ld_val;
      ld_now   = 1'b0;
    end else begin
      pc_load  = ($urandom_range(99) < p_load);
      pc_value = ($urandom_range(3) == 0) ? (8'hFE + 8'($urandom_range(1))) : 8'($urandom);
    end
    mem_valid = 1'b0;
    mem_data  = 16'($urandom);
    if (stale_now) begin
      mem_valid = 1'b1;
      mem_data  = 16'hDEAD;
      stale_now = 1'b0;
    end else if (m_pend && !just_req) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mem_valid = 1'b1;
        mem_data  = 16'hA000 | {8'h00, m_addr};
        m_pend    = 1'b0;
      end
    end

    if (pc_load) begin
      q.delete();
      f = pc_value;
      if (outst) begin
        if (mem_valid) begin
          outst = 1'b0;
          dropf = 1'b0;
        end else begin
          dropf = 1'b1;
        end
      end
    end else begin
      if (Done && q.size() != 0) void'(q.pop_front());
      if (mem_valid && outst) begin
        if (!dropf) q.push_back(16'hA000 | {8'h00, req_addr});
        dropf = 1'b0;
        outst = 1'b0;
      end
    end

    if (Run && !outst && !pc_load && q.size() < DEPTH) live++;
    else live = 0;
    if (live > 3) begin
      check("fetch_stall", live, 3);
      live = 0;
    end
  endtask

  task automatic do_reset(input bit stale);
    @(negedge clock);
    #2;
    Reset     = 1'b1;
    Run       = 1'b1;
    Done      = 1'b0;
    pc_load   = 1'b0;
    mem_valid = 1'b0;
    #1;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pc", pc, 0);
    check("rst_iin_valid", iin_valid, 0);
    check("rst_iin", iin, 0);
    q.delete();
    f         = 8'h00;
    outst     = 1'b0;
    dropf     = 1'b0;
    m_pend    = 1'b0;
    live      = 0;
    stale_now = stale;
    repeat (2) @(posedge clock);
    #1 Reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; Run = 1'b0; Done = 1'b0; pc_load = 1'b0;
    pc_value = 8'h00; mem_valid = 1'b0; mem_data = 16'h0000;

    // Latency 1, no consumer: two words prefetched, then stall.
    do_reset(1'b0);
    p_run = 100; p_done = 0; p_load = 0; lat_lo = 1; lat_hi = 1;
    repeat (12) cycle();
    check("fill_iin", iin, 16'hA000);
    check("fill_valid", iin_valid, 1);
    check("fill_pc", pc, 8'h02);
    check("fill_no_rd", mem_rd, 0);

    // Consumer pops every cycle, latency 3: in-order stream.
    p_done = 100; lat_lo = 3; lat_hi = 3;
    repeat (40) cycle();

    // Redirect to 0x40 while the read for address 5 is in flight.
    do_reset(1'b0);
    for (int i = 0; i < 200 && !(outst && req_addr == 8'd5); i++) cycle();
    check("reach_addr5", {23'd0, outst, req_addr}, {23'd0, 1'b1, 8'd5});
    p_done = 0;
    ld_now = 1'b1; ld_val = 8'h40;
    cycle();
    for (int i = 0; i < 50 && q.size() == 0; i++) cycle();
    cycle();
    check("redirect_word", iin, 16'hA040);

    // PC wrap: FF then 00.
    lat_lo = 1; lat_hi = 1;
    ld_now = 1'b1; ld_val = 8'hFF;
    repeat (15) cycle();
    check("wrap_head", iin, 16'hA0FF);
    check("wrap_pc", pc, 8'h01);
    p_done = 100;
    cycle();
    p_done = 0;
    cycle();
    check("wrap_next", iin, 16'hA000);

    // Random traffic with redirects and variable latency.
    p_run = 90; p_done = 50; p_load = 3; lat_lo = 1; lat_hi = 4;
    repeat (3000) cycle();
    p_run = 40; p_done = 30;
    repeat (500) cycle();

    // Reset while a read is outstanding; its late response must be ignored.
    p_run = 100; p_done = 0; p_load = 0; lat_lo = 4; lat_hi = 4;
    for (int i = 0; i < 50 && !outst; i++) cycle();
    check("reset_midwait_outst", outst, 1);
    do_reset(1'b1);
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 50 && q.size() == 0; i++) cycle();
    cycle();
    check("first_after_reset", iin, 16'hA000);

    p_run = 90; p_done = 50; p_load = 3; lat_lo = 1; lat_hi = 4;
    repeat (1000) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
